hr_reg_o: RTL
=============

HR_REG_O -- requirements
Module: hr_reg_o

Hour-ones digit stage of the 24-hour time register. It drives the inc input of the hour-tens digit register and consumes that register's hit2 flag.

Interface
REQ-001 SHALL have parameter MAX_AT_2, default 4'd3: the highest legal ones value while the tens digit is 2.
REQ-002 SHALL have parameter MAX_ONES, default 4'd9: the highest legal ones value otherwise.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port inc, input, 1: one-cycle carry pulse from the minutes stage.
REQ-006 SHALL have port set, input, 1: level; load new_val while high.
REQ-007 SHALL have port new_val, input, 4: requested ones value.
REQ-008 SHALL have port hit2_T, input, 1: tens digit equals 2.
REQ-009 SHALL have port Q, output, 4: current hour-ones digit, registered.
REQ-010 SHALL have port inc_T, output, 1: one-cycle carry pulse to the tens register, registered.
REQ-011 SHALL have port err, output, 1: sticky flag for a rejected set value.
REQ-012 SHALL have port state, output, 2: FSM state, for debug.

Function
REQ-013 SHALL implement FSM states RUN=2'b00, SET=2'b01 and FIX=2'b10; encoding 2'b11 SHALL go to RUN with Q unchanged.
REQ-014 RUN SHALL go to SET when set=1; SET SHALL return to RUN in the first cycle with set=0.
REQ-015 In RUN with inc=1, Q=MAX_AT_2 and hit2_T=1 (23->00): Q SHALL become 0 and inc_T SHALL be 1 in the next cycle.
REQ-016 In RUN with inc=1, Q=MAX_ONES and hit2_T=0 (x9->(x+1)0): Q SHALL become 0 and inc_T SHALL be 1 in the next cycle.
REQ-017 In RUN with inc=1 in any other case: Q SHALL become Q+1 and inc_T SHALL stay 0.
REQ-018 inc_T SHALL be high for exactly one cycle per wrap; Q updates on the same edge that samples inc, and the tens digit updates one edge later.
REQ-019 inc on back-to-back cycles SHALL each be counted; the wrap test uses current Q, so the stale hit2_T during the cycle after 23->00 SHALL NOT cause a second wrap.
REQ-020 In SET: if new_val is at or below the limit (MAX_AT_2 when hit2_T=1, else MAX_ONES), Q SHALL load new_val and err SHALL clear.
REQ-021 In SET with new_val above that limit: Q SHALL hold and err SHALL set.
REQ-022 In SET, inc SHALL be ignored: no count and no inc_T.
REQ-023 If set and inc are both high in RUN, set SHALL win: the FSM enters SET, new_val is evaluated in that same cycle and inc is dropped.
REQ-024 When hit2_T goes 0->1 (registered edge detect) while Q>MAX_AT_2, the FSM SHALL enter FIX for one cycle.
REQ-025 In FIX, Q SHALL be clamped to MAX_AT_2 and err SHALL set; FIX SHALL then go to RUN, or to SET if set=1.
REQ-026 In FIX, inc SHALL be ignored.
REQ-027 Q SHALL never exceed MAX_ONES, and SHALL never exceed MAX_AT_2 for more than 2 cycles after hit2_T rises.
REQ-028 The Q+1 increment SHALL be computed 4 bits wide with no overflow path.
REQ-029 err SHALL clear only on reset or on an accepted set.

Reset
REQ-030 With resetn=0 at a clock edge: Q=0, inc_T=0, err=0, state=RUN and the hit2_T edge register=0.
REQ-031 Reset SHALL override set, inc and FIX.
REQ-032 Reset asserted mid-FIX or mid-SET SHALL abort the operation with no inc_T pulse.
REQ-033 The first cycle after reset release SHALL evaluate inputs normally; a hit2_T already high at release SHALL NOT count as a rising edge.

Verification
REQ-034 Scenario: reset, then 10 inc pulses with hit2_T=0 -> Q goes 1..9 then 0; inc_T is high only in the cycle after the 10th pulse.
REQ-035 Scenario: hit2_T=1, Q=3, one inc pulse -> Q=0 next cycle and inc_T high for exactly one cycle; a second inc the following cycle -> Q=1 with no inc_T.
REQ-036 Scenario: set=1, new_val=7, hit2_T=1 -> Q holds and err=1; then new_val=2 -> Q=2 and err=0.
REQ-037 Scenario: Q=8 and hit2_T rises -> state=FIX for one cycle, then Q=3, err=1, state=RUN.
REQ-038 Scenario: set and inc high together at Q=4 with new_val=6 -> Q=6 and inc_T stays 0.
REQ-039 Scenario: resetn=0 during FIX or while set is held -> Q=0, err=0, state=RUN on the next edge and no inc_T.

Source files
------------

// File: rtl/hr_reg_o.sv
// Hour-ones digit of the 24-hour time register: counts minute carries, accepts
// checked set values, and clamps the digit when the tens digit becomes 2.
module hr_reg_o #(
    parameter logic [3:0] MAX_AT_2 = 4'd3,
    parameter logic [3:0] MAX_ONES = 4'd9
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       inc,
    input  logic       set,
    input  logic [3:0] new_val,
    input  logic       hit2_T,
    output logic [3:0] Q,
    output logic       inc_T,
    output logic       err,
    output logic [1:0] state
);

    localparam logic [1:0] ST_RUN = 2'b00;
    localparam logic [1:0] ST_SET = 2'b01;
    localparam logic [1:0] ST_FIX = 2'b10;

    logic [1:0] state_q, state_d;
    logic [3:0] q_q, q_d;
    logic       inc_t_q, inc_t_d;
    logic       err_q, err_d;
    logic       hit2_q, hit2_d;
    logic       armed_q, armed_d;
    logic       rise_s;
    logic       wrap_s;
    logic [3:0] limit_s;

    function automatic logic [3:0] limit_f(input logic tens_is_2);
        logic [3:0] lim;
        if (tens_is_2) begin
            lim = MAX_AT_2;
        end else begin
            lim = MAX_ONES;
        end
        return lim;
    endfunction

    // Next-state, digit, carry and error computation
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        inc_t_d = 1'b0;
        err_d   = err_q;
        hit2_d  = hit2_T;
        // armed_q masks a hit2_T that is already high when reset releases
        armed_d = 1'b1;
        limit_s = limit_f(hit2_T);
        rise_s  = hit2_T & ~hit2_q & armed_q;
        // >= rather than == keeps an out-of-range digit from counting past the limit
        wrap_s  = (q_q >= limit_s);

        case (state_q)
            ST_RUN: begin
                if (set) begin
                    state_d = ST_SET;
                    if (new_val <= limit_s) begin
                        q_d   = new_val;
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (rise_s && (q_q > MAX_AT_2)) begin
                    state_d = ST_FIX;
                end else if (inc) begin
                    if (wrap_s) begin
                        q_d     = 4'd0;
                        inc_t_d = 1'b1;
                    end else begin
                        q_d = q_q + 4'd1;
                    end
                end else begin
                    q_d = q_q;
                end
            end
            ST_SET: begin
                if (set) begin
                    if (new_val <= limit_s) begin
                        q_d   = new_val;
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FIX: begin
                q_d   = MAX_AT_2;
                err_d = 1'b1;
                if (set) begin
                    state_d = ST_SET;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_RUN;
            q_q     <= 4'd0;
            inc_t_q <= 1'b0;
            err_q   <= 1'b0;
            hit2_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            inc_t_q <= inc_t_d;
            err_q   <= err_d;
            hit2_q  <= hit2_d;
            armed_q <= armed_d;
        end
    end

    assign Q     = q_q;
    assign inc_T = inc_t_q;
    assign err   = err_q;
    assign state = state_q;

endmodule
